// File: rtl/csi_lane_dly_cal.sv
// csi_lane_dly_cal: per-lane IDELAY tap calibration for the CSI-2 D-PHY RX lanes.
// Sweeps taps 0..31 on one lane at a time, scores each tap from lane_ok hits and
// loads the centre of the widest passing window. A lane with no usable eye falls
// back to its DSKEW value and is flagged in lane_fail.
// Build option: define CSI_DLY_CAL_BYPASS_EN to drop the sweep and simply load
// DSKEW on every lane after start.

package top_pkg;
  localparam int NUM_LANE = 2;
  typedef logic [NUM_LANE-1:0][4:0] lane_dly_t;
  typedef logic [NUM_LANE-1:0]      lane_vld_t;
  localparam lane_dly_t DSKEW = {5'd3, 5'd3};
endpackage

module csi_lane_dly_cal
  import top_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW     = 256,
  parameter int MIN_HITS   = 4,
  parameter int MIN_EYE    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_LANE-1:0] lane_ok,
  output lane_dly_t           dly,
  output lane_vld_t           dly_ld,
  output logic                busy,
  output logic                done,
  output logic [NUM_LANE-1:0] lane_fail
);

`ifdef CSI_DLY_CAL_BYPASS_EN

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_LOAD, S_DONE} state_t;

  state_t    state_q, state_d;
  lane_dly_t dly_q, dly_d;
  lane_vld_t dly_ld_q, dly_ld_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      unused_ok;

  assign unused_ok = ^lane_ok;

  // Fixed three-step sequence: busy, then load DSKEW everywhere, then done.
  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    dly_ld_d = '0;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        busy_d   = 1'b0;
        dly_d    = DSKEW;
        dly_ld_d = '1;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dly_q    <= DSKEW;
      dly_ld_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      dly_ld_q <= dly_ld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dly       = dly_q;
  assign dly_ld    = dly_ld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lane_fail = '0;

`else

  localparam int LW   = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam int CMAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(MIN_HITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_SAMPLE, S_EVAL, S_FINAL, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [4:0]          tap_q, tap_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [HW-1:0]       hits_q, hits_d;
  logic [4:0]          cur_start_q, cur_start_d;
  logic [5:0]          cur_len_q, cur_len_d;
  logic [4:0]          best_start_q, best_start_d;
  logic [5:0]          best_len_q, best_len_d;
  lane_dly_t           dly_q, dly_d;
  lane_vld_t           dly_ld_q, dly_ld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NUM_LANE-1:0] lane_fail_q, lane_fail_d;

  logic       tap_pass;
  logic [5:0] run_len;
  logic [4:0] run_start;
  logic [4:0] half_len;
  logic [4:0] centre;

  // Tap scoring and run tracking helpers; a run can never extend past tap 31,
  // so the centre always fits in 5 bits.
  assign tap_pass  = (hits_q == HW'(MIN_HITS));
  assign run_len   = cur_len_q + 6'd1;
  assign run_start = (cur_len_q == 6'd0) ? tap_q : cur_start_q;
  assign half_len  = 5'((best_len_q - 6'd1) >> 1);
  assign centre    = best_start_q + half_len;

  // Next-state and next-output logic for the sweep controller.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    hits_d       = hits_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    dly_d        = dly_q;
    dly_ld_d     = '0;
    busy_d       = busy_q;
    done_d       = done_q;
    lane_fail_d  = lane_fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d       = 1'b0;
          lane_fail_d  = '0;
          busy_d       = 1'b1;
          lane_d       = '0;
          tap_d        = 5'd0;
          cur_start_d  = 5'd0;
          cur_len_d    = 6'd0;
          best_start_d = 5'd0;
          best_len_d   = 6'd0;
          state_d      = S_SET;
        end
      end
      S_SET: begin
        dly_d[lane_q]    = tap_q;
        dly_ld_d[lane_q] = 1'b1;
        cnt_d            = '0;
        hits_d           = '0;
        state_d          = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SAMPLE: begin
        if (lane_ok[lane_q] && (hits_q != HW'(MIN_HITS))) begin
          hits_d = hits_q + HW'(1);
        end
        if (cnt_q == CW'(WINDOW - 1)) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EVAL: begin
        if (tap_pass) begin
          cur_start_d = run_start;
          cur_len_d   = run_len;
          if (run_len > best_len_q) begin
            best_start_d = run_start;
            best_len_d   = run_len;
          end
        end else begin
          cur_len_d = 6'd0;
        end
        if (tap_q == 5'd31) begin
          state_d = S_FINAL;
        end else begin
          tap_d   = tap_q + 5'd1;
          state_d = S_SET;
        end
      end
      S_FINAL: begin
        if (best_len_q >= 6'(MIN_EYE)) begin
          dly_d[lane_q] = centre;
        end else begin
          dly_d[lane_q]       = DSKEW[lane_q];
          lane_fail_d[lane_q] = 1'b1;
        end
        dly_ld_d[lane_q] = 1'b1;
        if (lane_q == LW'(NUM_LANE - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          lane_d       = lane_q + LW'(1);
          tap_d        = 5'd0;
          cur_start_d  = 5'd0;
          cur_len_d    = 6'd0;
          best_start_d = 5'd0;
          best_len_d   = 6'd0;
          state_d      = S_SET;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, trackers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      tap_q        <= 5'd0;
      cnt_q        <= '0;
      hits_q       <= '0;
      cur_start_q  <= 5'd0;
      cur_len_q    <= 6'd0;
      best_start_q <= 5'd0;
      best_len_q   <= 6'd0;
      dly_q        <= DSKEW;
      dly_ld_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lane_fail_q  <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      hits_q       <= hits_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      dly_q        <= dly_d;
      dly_ld_q     <= dly_ld_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lane_fail_q  <= lane_fail_d;
    end
  end

  assign dly       = dly_q;
  assign dly_ld    = dly_ld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lane_fail = lane_fail_q;

`endif

endmodule

// File: tb/tb_csi_lane_dly_cal.sv
// tb_csi_lane_dly_cal: drives lane_ok from per-lane pass masks indexed by the
// tap currently applied, and checks the calibration result of each sweep.
module tb_csi_lane_dly_cal;
  import top_pkg::*;

  localparam int DSK = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [NUM_LANE-1:0] lane_ok;
  lane_dly_t           dly;
  lane_vld_t           dly_ld;
  logic                busy;
  logic                done;
  logic [NUM_LANE-1:0] lane_fail;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mask [NUM_LANE];

  typedef struct {
    string       name;
    logic [31:0] m0;
    logic [31:0] m1;
    int          e0;
    int          e1;
    int          efail;
    int          restart;
  } vec_t;

  always #5 clk = ~clk;

  csi_lane_dly_cal #(
    .SETTLE_CYC(4),
    .WINDOW    (16),
    .MIN_HITS  (1),
    .MIN_EYE   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .lane_ok  (lane_ok),
    .dly      (dly),
    .dly_ld   (dly_ld),
    .busy     (busy),
    .done     (done),
    .lane_fail(lane_fail)
  );

  // Emulated aligner: random single-cycle hits on taps inside the lane's eye.
  initial begin
    lane_ok = '0;
    forever begin
      @(negedge clk);
      for (int l = 0; l < NUM_LANE; l++) begin
        lane_ok[l] = mask[l][dly[l]] && ($urandom_range(3) != 0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: widest contiguous run of passing taps, lowest start wins ties.
  function automatic void ref_lane(input logic [31:0] m, output int d, output int f);
    int bl = 0;
    int bs = 0;
    int len;
    for (int s = 0; s < 32; s++) begin
      if (m[s] && (s == 0 || !m[s-1])) begin
        len = 0;
        while ((s + len) < 32 && m[s+len]) len++;
        if (len > bl) begin
          bl = len;
          bs = s;
        end
      end
    end
    if (bl >= 3) begin
      d = bs + (bl - 1) / 2;
      f = 0;
    end else begin
      d = DSK;
      f = 1;
    end
  endfunction

  task automatic run_cal(input string name, input int restart_at,
                         input int exp0, input int exp1, input int expf);
    int busy_cyc = 0;
    int n0 = 0;
    int n1 = 0;
    int done_at_start = 1;
    bit order_ok = 1'b1;
    bit fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      start = (c == restart_at);
      if (c == 0) done_at_start = int'(done);
      if (busy) busy_cyc++;
      if (dly_ld[0]) begin
        n0++;
        if (n1 != 0) order_ok = 1'b0;
      end
      if (dly_ld[1]) n1++;
      if (done) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    $display("run %s: dly0=%0d dly1=%0d lane_fail=%b busy_cycles=%0d ld0=%0d ld1=%0d",
             name, dly[0], dly[1], lane_fail, busy_cyc, n0, n1);
    chk({name, " finished"},      int'(fin), 1);
    chk({name, " done cleared"},  done_at_start, 0);
    chk({name, " dly0"},          int'(dly[0]), exp0);
    chk({name, " dly1"},          int'(dly[1]), exp1);
    chk({name, " lane_fail"},     int'(lane_fail), expf);
    chk({name, " busy cycles"},   busy_cyc, 2 * (32 * 22 + 1));
    chk({name, " ld0 pulses"},    n0, 33);
    chk({name, " ld1 pulses"},    n1, 33);
    chk({name, " ld order"},      int'(order_ok), 1);
    @(posedge clk);
    #1;
    chk({name, " done sticky"},   int'(done), 1);
    chk({name, " busy idle"},     int'(busy), 0);
  endtask

  initial begin
    vec_t vecs [5];
    int   n0;
    bit   hit;
    int   d0, d1, f0, f1, r, ln;
    logic [31:0] m0, m1;

    vecs[0] = '{"happy",   32'h0000FF00, 32'h3FF00007, 11, 24, 0, -1};
    vecs[1] = '{"narrow",  32'h00000060, 32'h3FF00007,  3, 24, 1, -1};
    vecs[2] = '{"edge",    32'hF0000000, 32'h00003C3C, 29,  3, 0, -1};
    vecs[3] = '{"restart", 32'h0000FF00, 32'h3FF00007, 11, 24, 0, 300};
    vecs[4] = '{"full",    32'hFFFFFFFF, 32'h00000000, 15,  3, 2, -1};

    mask[0] = '0;
    mask[1] = '0;
    rst     = 1'b1;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dly0",      int'(dly[0]), DSK);
    chk("reset dly1",      int'(dly[1]), DSK);
    chk("reset dly_ld",    int'(dly_ld), 0);
    chk("reset busy",      int'(busy), 0);
    chk("reset done",      int'(done), 0);
    chk("reset lane_fail", int'(lane_fail), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle busy", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      mask[0] = vecs[i].m0;
      mask[1] = vecs[i].m1;
      run_cal(vecs[i].name, vecs[i].restart, vecs[i].e0, vecs[i].e1, vecs[i].efail);
    end

    // Reset in the middle of lane0's sweep, right after tap 17 is loaded.
    mask[0] = 32'h0000FF00;
    mask[1] = 32'h3FF00007;
    n0  = 0;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (dly_ld[0]) n0++;
      if (n0 == 18) begin
        hit = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("midrst reached tap17", int'(hit), 1);
    chk("midrst dly0 at tap17", int'(dly[0]), 17);
    chk("midrst busy before",   int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    $display("mid-sweep reset: dly0=%0d dly1=%0d busy=%b done=%b", dly[0], dly[1], busy, done);
    chk("midrst dly0",      int'(dly[0]), DSK);
    chk("midrst dly1",      int'(dly[1]), DSK);
    chk("midrst dly_ld",    int'(dly_ld), 0);
    chk("midrst busy",      int'(busy), 0);
    chk("midrst done",      int'(done), 0);
    chk("midrst lane_fail", int'(lane_fail), 0);
    @(negedge clk);
    rst = 1'b0;
    run_cal("after_rst", -1, 11, 24, 0);

    // Randomised eyes checked against the run-length reference.
    for (int i = 0; i < 3; i++) begin
      m0 = $urandom() & $urandom();
      m1 = $urandom() & $urandom() & $urandom();
      r  = $urandom_range(31);
      ln = $urandom_range(10, 1);
      for (int b = r; b < 32 && b < r + ln; b++) m0[b] = 1'b1;
      mask[0] = m0;
      mask[1] = m1;
      ref_lane(m0, d0, f0);
      ref_lane(m1, d1, f1);
      run_cal($sformatf("rand%0d", i), -1, d0, d1, f0 | (f1 << 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
